// File: rtl/med_feeder_if.sv
// Window handshake between an upstream 3x3 window source and med_feeder.
//   win_in    : SIZE pixels of WIDTH bits; pixel k at [k*WIDTH +: WIDTH]
//   win_valid : win_in holds a valid window (source -> feeder)
//   win_ready : feeder can accept a window (feeder -> source)
interface med_feeder_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned SIZE  = 9
);
    logic [SIZE*WIDTH-1:0] win_in;
    logic                  win_valid;
    logic                  win_ready;

    modport master (output win_in, output win_valid, input win_ready);
    modport slave  (input win_in, input win_valid, output win_ready);
endinterface

// File: rtl/med_feeder.sv
// Serialises a 3x3 pixel window into an external median operator, sequences
// its sort passes and captures the median it produces.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   win        : window handshake (slave side)
//   med_di     : serial pixel to the operator
//   med_dsi    : shift-in strobe to the operator
//   med_byp    : bypass/shift control to the operator
//   med_do     : operator result
//   median_out : last captured median, held until the next capture
//   dso        : one-cycle pulse after median_out is updated
//   busy       : a window is in progress
// Only SIZE = 9 is supported.
module med_feeder #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned SIZE  = 9
) (
    input  logic             clk,
    input  logic             reset,
    med_feeder_if.slave      win,
    output logic [WIDTH-1:0] med_di,
    output logic             med_dsi,
    output logic             med_byp,
    input  logic [WIDTH-1:0] med_do,
    output logic [WIDTH-1:0] median_out,
    output logic             dso,
    output logic             busy
);
    localparam int unsigned CNT_W      = 6;
    localparam int unsigned IDX_W      = $clog2(SIZE);
    localparam int unsigned PASS_W     = 2;
    localparam int unsigned LOAD_LAST  = SIZE - 1;
    localparam int unsigned SORT_LAST  = 4 * SIZE - 1;
    localparam int unsigned FINAL_LAST = 3;

    typedef enum logic [2:0] {IDLE, LOAD, SORT, FINAL, CAPTURE} state_t;

    state_t            state, nxt_state;
    logic [CNT_W-1:0]  cnt, nxt_cnt;
    logic [IDX_W-1:0]  idx, nxt_idx;
    logic [PASS_W-1:0] pass, nxt_pass;
    logic [WIDTH-1:0]  pix [SIZE];
    logic              ready_q;
    logic              nxt_ready, nxt_busy, nxt_dsi, nxt_byp;
    logic [WIDTH-1:0]  nxt_di;

    assign win.win_ready = ready_q;

    // State and sequencing counters
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            pass  <= '0;
        end else begin
            state <= nxt_state;
            cnt   <= nxt_cnt;
            idx   <= nxt_idx;
            pass  <= nxt_pass;
        end
    end

    // Window register: written only on acceptance, frozen otherwise
    always_ff @(posedge clk) begin
        if (!reset && state == IDLE && win.win_valid) begin
            for (int k = 0; k < int'(SIZE); k++) begin
                pix[k] <= win.win_in[k*WIDTH +: WIDTH];
            end
        end
    end

    // Next state, counters, and the output values for the state being entered
    always_comb begin
        nxt_state = state;
        nxt_cnt   = cnt + CNT_W'(1);
        nxt_idx   = idx;
        nxt_pass  = pass;
        nxt_ready = 1'b0;
        nxt_busy  = 1'b1;
        nxt_dsi   = 1'b0;
        nxt_byp   = 1'b0;
        nxt_di    = '0;

        unique case (state)
            IDLE: begin
                nxt_cnt = '0;
                if (win.win_valid) begin
                    nxt_state = LOAD;
                    nxt_idx   = '0;
                    nxt_pass  = '0;
                end
            end
            LOAD: begin
                nxt_idx = idx + IDX_W'(1);
                if (cnt == CNT_W'(LOAD_LAST)) begin
                    nxt_state = SORT;
                    nxt_cnt   = '0;
                    nxt_idx   = '0;
                end
            end
            SORT: begin
                if (idx == IDX_W'(SIZE - 1)) begin
                    nxt_idx  = '0;
                    nxt_pass = pass + PASS_W'(1);
                end else begin
                    nxt_idx = idx + IDX_W'(1);
                end
                if (cnt == CNT_W'(SORT_LAST)) begin
                    nxt_state = FINAL;
                    nxt_cnt   = '0;
                    nxt_idx   = '0;
                    nxt_pass  = '0;
                end
            end
            FINAL: begin
                if (cnt == CNT_W'(FINAL_LAST)) begin
                    nxt_state = CAPTURE;
                    nxt_cnt   = '0;
                end
            end
            CAPTURE: begin
                nxt_state = IDLE;
                nxt_cnt   = '0;
            end
            default: begin
                nxt_state = IDLE;
                nxt_cnt   = '0;
                nxt_idx   = '0;
                nxt_pass  = '0;
            end
        endcase

        // Outputs are registered, so decode from the upcoming state/index.
        // On the accepting edge the window register is not yet loaded,
        // so pixel 0 comes straight from the bus.
        case (nxt_state)
            IDLE: begin
                nxt_ready = 1'b1;
                nxt_busy  = 1'b0;
            end
            LOAD: begin
                nxt_dsi = 1'b1;
                nxt_byp = 1'b1;
                nxt_di  = (state == IDLE) ? win.win_in[WIDTH-1:0] : pix[nxt_idx];
            end
            SORT: nxt_byp = (nxt_idx == IDX_W'(SIZE - 1));
            default: ;
        endcase
    end

    // Registered outputs; median capture happens at the end of CAPTURE
    always_ff @(posedge clk) begin
        if (reset) begin
            ready_q    <= 1'b1;
            busy       <= 1'b0;
            med_dsi    <= 1'b0;
            med_byp    <= 1'b0;
            med_di     <= '0;
            dso        <= 1'b0;
            median_out <= '0;
        end else begin
            ready_q <= nxt_ready;
            busy    <= nxt_busy;
            med_dsi <= nxt_dsi;
            med_byp <= nxt_byp;
            med_di  <= nxt_di;
            dso     <= (state == CAPTURE);
            if (state == CAPTURE) begin
                median_out <= med_do;
            end
        end
    end
endmodule

// File: tb/tb_med_feeder.sv
// Self-checking bench for med_feeder with a behavioural median operator.
module tb_med_feeder;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned SIZE  = 9;
    localparam int unsigned WW    = WIDTH * SIZE;
    localparam int unsigned OBS_W = WIDTH + 5;

    logic             clk = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] med_di, med_do, median_out;
    logic             med_dsi, med_byp, dso, busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int last_dso = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    med_feeder_if #(.WIDTH(WIDTH), .SIZE(SIZE)) win ();

    med_feeder #(.WIDTH(WIDTH), .SIZE(SIZE)) dut (
        .clk        (clk),
        .reset      (reset),
        .win        (win),
        .med_di     (med_di),
        .med_dsi    (med_dsi),
        .med_byp    (med_byp),
        .med_do     (med_do),
        .median_out (median_out),
        .dso        (dso),
        .busy       (busy)
    );

    // Reference median: plain sort of the nine pixels
    function automatic logic [WIDTH-1:0] median_of(input logic [WW-1:0] w);
        int v[SIZE];
        int t;
        for (int k = 0; k < int'(SIZE); k++) v[k] = int'(w[k*WIDTH +: WIDTH]);
        for (int i = 1; i < int'(SIZE); i++) begin
            for (int j = i; j > 0; j--) begin
                if (v[j] < v[j-1]) begin
                    t = v[j]; v[j] = v[j-1]; v[j-1] = t;
                end
            end
        end
        return WIDTH'(v[SIZE/2]);
    endfunction

    // Median operator model: collects shifted-in pixels and only presents the
    // true median after exactly 36 non-bypass, non-shift cycles; otherwise it
    // presents the complement so a mistimed capture is visible.
    logic [WW-1:0] med_store = '0;
    int            med_settle = 0;
    always @(posedge clk) begin
        if (reset) begin
            med_store  <= '0;
            med_settle <= 0;
        end else if (med_dsi) begin
            med_store  <= {med_di, med_store[WW-1:WIDTH]};
            med_settle <= 0;
        end else if (!med_byp && med_settle < 1000) begin
            med_settle <= med_settle + 1;
        end
    end
    always_comb med_do = (med_settle == 36) ? median_of(med_store) : ~median_of(med_store);

    function automatic logic [WW-1:0] mk9(input int a0, input int a1, input int a2,
                                          input int a3, input int a4, input int a5,
                                          input int a6, input int a7, input int a8);
        logic [WW-1:0] w;
        int p[SIZE];
        p = '{a0, a1, a2, a3, a4, a5, a6, a7, a8};
        for (int k = 0; k < int'(SIZE); k++) w[k*WIDTH +: WIDTH] = WIDTH'(p[k]);
        return w;
    endfunction

    function automatic logic [OBS_W-1:0] obs();
        return {win.win_ready, busy, med_dsi, med_byp, med_di, dso};
    endfunction

    function automatic logic [OBS_W-1:0] idle_vec();
        logic [WIDTH-1:0] z;
        z = '0;
        return {1'b1, 1'b0, 1'b0, 1'b0, z, 1'b0};
    endfunction

    // Expected outputs in cycle c after the accepting edge (c = 1 is first LOAD)
    function automatic logic [OBS_W-1:0] expect_vec(input int c, input logic [WW-1:0] w);
        logic rdy, bsy, dsi, byp, so;
        logic [WIDTH-1:0] di;
        rdy = 1'b0; bsy = 1'b1; dsi = 1'b0; byp = 1'b0; di = '0; so = 1'b0;
        if (c <= 9) begin
            dsi = 1'b1; byp = 1'b1; di = w[(c-1)*WIDTH +: WIDTH];
        end else if (c <= 45) begin
            byp = (((c - 10) % 9) == 8);
        end else if (c == 51) begin
            rdy = 1'b1; bsy = 1'b0; so = 1'b1;
        end
        return {rdy, bsy, dsi, byp, di, so};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Called at a negedge in IDLE; presents w, then checks every cycle through dso.
    // Returns at the negedge of the dso cycle with win_valid low.
    task automatic run_window(input string name, input logic [WW-1:0] w,
                              input logic [WIDTH-1:0] exp_med, input bit junk);
        win.win_in    = w;
        win.win_valid = 1'b1;
        check({name, " ready"}, 64'(win.win_ready), 64'(1));
        @(negedge clk);
        win.win_valid = 1'b0;
        for (int c = 1; c <= 51; c++) begin
            check($sformatf("%s c%0d", name, c), 64'(obs()), 64'(expect_vec(c, w)));
            if (junk) begin
                win.win_in    = '0;
                win.win_valid = (c >= 9 && c <= 44);
            end
            if (c < 51) @(negedge clk);
        end
        check({name, " median"}, 64'(median_out), 64'(exp_med));
        last_dso = cyc;
    endtask

    typedef struct {
        string            name;
        logic [WW-1:0]    w;
        logic [WIDTH-1:0] med;
        bit               junk;
    } vec_t;

    vec_t tbl[6];

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [WW-1:0] w;
        int t0;

        tbl[0] = '{"basic",   mk9(1, 2, 3, 4, 5, 6, 7, 8, 9),               8'd5,   1'b0};
        tbl[1] = '{"dups",    mk9(200, 3, 3, 255, 0, 7, 7, 7, 128),         8'd7,   1'b0};
        tbl[2] = '{"ignored", mk9(9, 8, 7, 6, 5, 4, 3, 2, 1),               8'd5,   1'b1};
        tbl[3] = '{"all255",  mk9(255, 255, 255, 255, 255, 255, 255, 255, 255), 8'd255, 1'b0};
        tbl[4] = '{"allzero", mk9(0, 0, 0, 0, 0, 0, 0, 0, 0),               8'd0,   1'b0};
        tbl[5] = '{"tens",    mk9(90, 10, 80, 20, 70, 30, 60, 40, 50),      8'd50,  1'b0};

        reset = 1'b1;
        win.win_valid = 1'b0;
        win.win_in = '0;
        repeat (3) @(negedge clk);
        check("reset obs", 64'(obs()), 64'(idle_vec()));
        check("reset median", 64'(median_out), 64'(0));
        reset = 1'b0;
        @(negedge clk);
        check("post-reset obs", 64'(obs()), 64'(idle_vec()));

        // win_valid coincident with reset must not be accepted
        reset = 1'b1;
        win.win_valid = 1'b1;
        win.win_in = mk9(9, 9, 9, 9, 9, 9, 9, 9, 9);
        @(negedge clk);
        reset = 1'b0;
        win.win_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("valid-in-reset", 64'(obs()), 64'(idle_vec()));
            @(negedge clk);
        end

        for (int i = 0; i < 6; i++) begin
            run_window(tbl[i].name, tbl[i].w, tbl[i].med, tbl[i].junk);
            @(negedge clk);
        end

        // Back-to-back: B presented in A's dso cycle
        run_window("b2b-A", mk9(10, 20, 30, 40, 50, 60, 70, 80, 90), 8'd50, 1'b0);
        t0 = last_dso;
        run_window("b2b-B", mk9(255, 255, 255, 255, 255, 255, 255, 255, 255), 8'd255, 1'b0);
        check("b2b spacing", 64'(last_dso - t0), 64'(51));
        @(negedge clk);

        // Reset in SORT pass 2 cycle 3 discards the window
        win.win_in = mk9(1, 2, 3, 4, 5, 6, 7, 8, 9);
        win.win_valid = 1'b1;
        @(negedge clk);
        win.win_valid = 1'b0;
        repeat (30) @(negedge clk);
        check("pre-reset busy", 64'(busy), 64'(1));
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midreset obs", 64'(obs()), 64'(idle_vec()));
        check("midreset median", 64'(median_out), 64'(0));
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            check("midreset quiet", 64'(obs()), 64'(idle_vec()));
        end
        run_window("after-reset", mk9(1, 2, 3, 4, 5, 6, 7, 8, 9), 8'd5, 1'b0);

        // Idle hold
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            check("idle hold", 64'({obs(), median_out}), 64'({idle_vec(), 8'd5}));
        end

        // Randomized windows against the sort reference
        for (int i = 0; i < 30; i++) begin
            for (int k = 0; k < int'(SIZE); k++) begin
                w[k*WIDTH +: WIDTH] = (i % 2 == 1) ? WIDTH'($urandom_range(0, 7))
                                                   : WIDTH'($urandom_range(0, 255));
            end
            run_window($sformatf("rand%0d", i), w, median_of(w), ($urandom_range(0, 3) == 0));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
